uart_rx_core: RTL

Parametrised, runtime-configurable UART receiver: the next-generation RX path.
- Takes a raw asynchronous serial line and delivers words over a valid/ready interface to the upstream FIFO.
- Generates the per-word status feeding the IRQ/status registers: rx_done, uart_parity_err, uart_bad_frame and rx_status. Also generates overrun and break.
- Adds over the fixed 8N1 path: 5-9 data bits, 5 parity modes, 1/2 stop bits, majority-vote sampling, break detection.

---
 rtl/uart_pkg.sv | 7 +
 rtl/uart_os_tick_gen.sv | 33 +++
 rtl/uart_rx_core.sv | 129 ++++++++++++
 3 files changed

// File: rtl/uart_pkg.sv
// uart_pkg: shared UART types and default parameters
package uart_pkg;
  localparam int UART_OVERSAMPLE_DEF = 16;
  localparam int UART_DATA_W_MAX_DEF = 9;
  typedef enum logic [2:0] {PAR_NONE, PAR_EVEN, PAR_ODD, PAR_MARK, PAR_SPACE} uart_parity_t;
  typedef enum logic [2:0] {RX_IDLE, RX_START, RX_DATA, RX_PARITY, RX_STOP, RX_BRK_WAIT} uart_rx_state_t;
endpackage

// File: rtl/uart_os_tick_gen.sv
// uart_os_tick_gen: baud prescaler and oversample-tick counter with vote/bit-end strobes
module uart_os_tick_gen
  import uart_pkg::*;
#(
  parameter int OVERSAMPLE = UART_OVERSAMPLE_DEF,
  parameter int BAUD_DIV_W = 16
) (
  input  logic                  clk_i,
  input  logic                  rstn_i,
  input  logic                  clr_i,
  input  logic                  run_i,
  input  logic [BAUD_DIV_W-1:0] div_i,
  output logic                  tick_o,
  output logic                  vote_o,
  output logic                  bit_end_o
);
  localparam int CW = $clog2(OVERSAMPLE);
  logic [BAUD_DIV_W-1:0] pre, lim;
  logic [CW-1:0] cnt;
  assign lim = div_i == '0 ? BAUD_DIV_W'(1) : div_i;
  assign tick_o = run_i && pre == lim - BAUD_DIV_W'(1);
  assign vote_o = tick_o && cnt == CW'(OVERSAMPLE / 2 + 1);
  assign bit_end_o = tick_o && cnt == CW'(OVERSAMPLE - 1);
  always_ff @(posedge clk_i) begin
    if (!rstn_i || clr_i) begin
      pre <= '0;
      cnt <= '0;
    end else if (run_i) begin
      pre <= tick_o ? '0 : pre + BAUD_DIV_W'(1);
      if (tick_o) cnt <= cnt == CW'(OVERSAMPLE - 1) ? '0 : cnt + CW'(1);
    end
  end
endmodule

// File: rtl/uart_rx_core.sv
// uart_rx_core: configurable oversampling UART receiver with valid/ready output
module uart_rx_core
  import uart_pkg::*;
#(
  parameter int DATA_W_MAX = UART_DATA_W_MAX_DEF,
  parameter int OVERSAMPLE = UART_OVERSAMPLE_DEF,
  parameter int BAUD_DIV_W = 16
) (
  input  logic                  clk_i,
  input  logic                  rstn_i,
  input  logic                  cfg_en_i,
  input  logic [BAUD_DIV_W-1:0] cfg_baud_div_i,
  input  logic [3:0]            cfg_data_bits_i,
  input  logic [2:0]            cfg_parity_i,
  input  logic                  cfg_stop2_i,
  input  logic                  rx_i,
  output logic [DATA_W_MAX-1:0] rx_data_o,
  output logic                  rx_valid_o,
  input  logic                  rx_ready_i,
  output logic                  rx_parity_err_o,
  output logic                  rx_frame_err_o,
  output logic                  overrun_o,
  output logic                  break_o,
  output logic                  busy_o
);
  uart_rx_state_t state, nxt;
  uart_parity_t par;
  logic s1, s2, s3, v, start, tick, vote_pt, bit_end, last_data, last_stop, brk, done;
  logic stop2, dpar, pexp, perr, ferr, zero;
  logic [1:0] hist;
  logic [3:0] nb, bcnt;
  logic [BAUD_DIV_W-1:0] div;
  logic [DATA_W_MAX-1:0] sh;
  assign v = (hist[1] & hist[0]) | (hist[1] & s2) | (hist[0] & s2);
  assign start = cfg_en_i && state == RX_IDLE && s3 && !s2;
  assign pexp = par == PAR_EVEN ? dpar : par == PAR_ODD ? !dpar : par == PAR_MARK;
  uart_os_tick_gen #(.OVERSAMPLE(OVERSAMPLE), .BAUD_DIV_W(BAUD_DIV_W)) u_tick (
    .clk_i    (clk_i),
    .rstn_i   (rstn_i),
    .clr_i    (start),
    .run_i    (state != RX_IDLE),
    .div_i    (div),
    .tick_o   (tick),
    .vote_o   (vote_pt),
    .bit_end_o(bit_end)
  );
  always_ff @(posedge clk_i) begin
    if (!rstn_i) state <= RX_IDLE;
    else state <= nxt;
  end
  always_comb begin
    nxt = state;
    if (!cfg_en_i) nxt = RX_IDLE;
    else
      case (state)
        RX_IDLE:     nxt = start ? RX_START : RX_IDLE;
        RX_START:    nxt = vote_pt && v ? RX_IDLE : bit_end ? RX_DATA : RX_START;
        RX_DATA:     nxt = bit_end && last_data ? (par == PAR_NONE ? RX_STOP : RX_PARITY) : RX_DATA;
        RX_PARITY:   nxt = bit_end ? RX_STOP : RX_PARITY;
        RX_STOP:     nxt = brk ? RX_BRK_WAIT : done ? RX_IDLE : RX_STOP;
        RX_BRK_WAIT: nxt = s2 ? RX_IDLE : RX_BRK_WAIT;
        default:     nxt = RX_IDLE;
      endcase
  end
  always_comb begin
    busy_o = state != RX_IDLE;
    last_data = bcnt == nb - 4'd1;
    last_stop = bcnt == {3'd0, stop2};
    brk = cfg_en_i && state == RX_STOP && vote_pt && bcnt == 4'd0 && zero && !v;
    done = cfg_en_i && state == RX_STOP && vote_pt && last_stop && !brk;
  end
  always_ff @(posedge clk_i) begin
    if (!rstn_i) begin
      {s1, s2, s3} <= 3'b111;
      hist <= 2'b11;
      div <= '0;
      nb <= 4'd5;
      par <= PAR_NONE;
      stop2 <= 1'b0;
      bcnt <= '0;
      sh <= '0;
      dpar <= 1'b0;
      perr <= 1'b0;
      ferr <= 1'b0;
      zero <= 1'b0;
      rx_data_o <= '0;
      rx_valid_o <= 1'b0;
      rx_parity_err_o <= 1'b0;
      rx_frame_err_o <= 1'b0;
      overrun_o <= 1'b0;
      break_o <= 1'b0;
    end else begin
      {s1, s2, s3} <= {rx_i, s1, s2};
      if (tick) hist <= {hist[0], s2};
      if (start) begin
        div <= cfg_baud_div_i;
        nb <= cfg_data_bits_i < 4'd5 ? 4'd5 : cfg_data_bits_i > 4'(DATA_W_MAX) ? 4'(DATA_W_MAX) : cfg_data_bits_i;
        par <= cfg_parity_i > 3'(PAR_SPACE) ? PAR_NONE : uart_parity_t'(cfg_parity_i);
        stop2 <= cfg_stop2_i;
        bcnt <= '0;
        sh <= '0;
        dpar <= 1'b0;
        perr <= 1'b0;
        ferr <= 1'b0;
        zero <= 1'b1;
      end
      if (vote_pt && state == RX_DATA) begin
        sh[bcnt] <= v;
        dpar <= dpar ^ v;
        zero <= zero & !v;
      end
      if (vote_pt && state == RX_PARITY) begin
        perr <= v != pexp;
        zero <= zero & !v;
      end
      if (vote_pt && state == RX_STOP) ferr <= ferr | !v;
      if (bit_end && (state == RX_DATA || state == RX_STOP))
        bcnt <= state == RX_DATA && last_data ? 4'd0 : bcnt + 4'd1;
      overrun_o <= done && rx_valid_o && !rx_ready_i;
      break_o <= brk;
      if (done && (!rx_valid_o || rx_ready_i)) begin
        rx_data_o <= sh;
        rx_parity_err_o <= perr;
        rx_frame_err_o <= ferr | !v;
        rx_valid_o <= 1'b1;
      end else if (rx_valid_o && rx_ready_i) rx_valid_o <= 1'b0;
    end
  end
endmodule
